// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the FP32 accumulator slice: field widths, the packed
// {sign, exp, man} view of an IEEE-754 single, and the accumulator FSM states.
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // All-ones exponent: Inf (NaN is not distinguished from Inf here).
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Smallest biased exponent that no longer fits a finite number.
    localparam int EXP_INF = 2 * BIAS + 1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_OUT
    } acc_state_t;

    function automatic logic is_inf(input fp32_t v);
        return v.exp == EXP_MAX;
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// -----------------------------------------------------------------------------
// fp32_lzc
// Combinational leading-zero counter for the normalize step.
//   value : WIDTH-bit magnitude to scan (MSB first)
//   count : number of zeros above the most significant one; WIDTH when zero
// -----------------------------------------------------------------------------
module fp32_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        count = CNT_W'(WIDTH);
        // Scanning upwards, the highest set bit is the last one to write.
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_accumulator.sv
// -----------------------------------------------------------------------------
// fp32_accumulator
// Sequential FP32 adder that sums a packet of products into a running total.
// One addend per transaction; align, add and normalize take one cycle each;
// the packet sum is presented when the addend tagged in_last has been absorbed.
// Truncation rounding, denormals flushed to zero, overflow saturates to +/-Inf.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   in_valid/ready  : addend handshake; in_data is the FP32 addend,
//                     in_last marks the final addend of a packet
//   out_valid/ready : result handshake; out_data is the packet sum,
//                     out_ovf flags an overflow to Inf within the packet
// -----------------------------------------------------------------------------
module fp32_accumulator
    import fp32_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_ovf,
    input  logic        out_ready
);

    localparam int MW    = 24 + GUARD_BITS;     // hidden bit + fraction + guards
    localparam int SW    = MW + 1;              // sum keeps the carry
    localparam int CNT_W = $clog2(MW + 1);
    localparam int DW    = EXP_W + 2;           // signed exponent headroom

    acc_state_t state, state_nxt;

    fp32_t            acc_q;
    logic             ovf_q;
    fp32_t            add_q;
    logic             last_q;

    logic             a_sign_q;
    logic [EXP_W-1:0] a_exp_q;
    logic [MW-1:0]    a_man_q;
    logic [MW-1:0]    b_man_q;
    logic             sub_q;
    logic             inf_q;       // result is forced to an infinity
    fp32_t            inf_val_q;

    logic [SW-1:0]    sum_q;

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_ALIGN;
            ST_ALIGN: state_nxt = ST_ADD;
            ST_ADD:   state_nxt = ST_NORM;
            ST_NORM:  state_nxt = last_q ? ST_OUT : ST_IDLE;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
    end

    assign out_data = acc_q;
    assign out_ovf  = ovf_q;

    // -------------------------------------------------------------- ALIGN ---
    fp32_t            op_x, op_y;
    logic [MW-1:0]    man_x, man_y;
    logic             swap;
    logic             big_sign, small_sign;
    logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
    logic [MW-1:0]    big_man, small_man, small_shifted;

    always_comb begin
        op_x  = add_q;
        op_y  = acc_q;
        // A zero exponent is exact zero: the mantissa is ignored.
        man_x = (op_x.exp == '0) ? '0 : {1'b1, op_x.man, {GUARD_BITS{1'b0}}};
        man_y = (op_y.exp == '0) ? '0 : {1'b1, op_y.man, {GUARD_BITS{1'b0}}};

        // Operand A is the larger magnitude; ties keep the addend as A.
        swap       = {op_y.exp, man_y} > {op_x.exp, man_x};
        big_sign   = swap ? op_y.sign : op_x.sign;
        big_exp    = swap ? op_y.exp  : op_x.exp;
        big_man    = swap ? man_y     : man_x;
        small_sign = swap ? op_x.sign : op_y.sign;
        small_exp  = swap ? op_x.exp  : op_y.exp;
        small_man  = swap ? man_x     : man_y;

        exp_diff      = big_exp - small_exp;
        small_shifted = (int'(exp_diff) >= MW) ? '0 : (small_man >> exp_diff);
    end

    // ---------------------------------------------------------------- ADD ---
    logic [SW-1:0] sum_d;

    always_comb begin
        sum_d = sub_q ? ({1'b0, a_man_q} - {1'b0, b_man_q})
                      : ({1'b0, a_man_q} + {1'b0, b_man_q});
    end

    // --------------------------------------------------------------- NORM ---
    logic [CNT_W-1:0]     lz;
    logic [MW-1:0]        norm_man;
    logic signed [DW-1:0] norm_exp;
    fp32_t                res;
    logic                 res_ovf;
    logic                 unused_norm;

    fp32_lzc #(
        .WIDTH (MW),
        .CNT_W (CNT_W)
    ) u_lzc (
        .value (sum_q[MW-1:0]),
        .count (lz)
    );

    always_comb begin
        if (sum_q[SW-1]) begin
            norm_man = sum_q[SW-1:1];
            norm_exp = DW'(a_exp_q) + DW'(1);
        end else begin
            norm_man = sum_q[MW-1:0] << lz;
            norm_exp = DW'(a_exp_q) - DW'(lz);
        end

        res_ovf = 1'b0;
        if (inf_q) begin
            res     = inf_val_q;
            res_ovf = 1'b1;
        end else if (sum_q == '0 || norm_exp <= 0) begin
            res = '0;
        end else if (norm_exp >= EXP_INF) begin
            res     = '{sign: a_sign_q, exp: EXP_MAX, man: '0};
            res_ovf = 1'b1;
        end else begin
            // Drop the hidden bit on top and truncate the guard bits below.
            res = '{sign: a_sign_q,
                    exp:  norm_exp[EXP_W-1:0],
                    man:  norm_man[MW-2 -: MAN_W]};
        end
    end

    // Hidden bit and guard bits of norm_man are intentionally discarded.
    assign unused_norm = ^norm_man;

    // ----------------------------------------------------------- datapath ---
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            add_q     <= '0;
            last_q    <= 1'b0;
            a_sign_q  <= 1'b0;
            a_exp_q   <= '0;
            a_man_q   <= '0;
            b_man_q   <= '0;
            sub_q     <= 1'b0;
            inf_q     <= 1'b0;
            inf_val_q <= '0;
            sum_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        add_q  <= in_data;
                        last_q <= in_last;
                    end
                end
                ST_ALIGN: begin
                    a_sign_q <= big_sign;
                    a_exp_q  <= big_exp;
                    a_man_q  <= big_man;
                    b_man_q  <= small_shifted;
                    sub_q    <= big_sign ^ small_sign;
                    // An infinite accumulator sticks; otherwise an infinite
                    // addend replaces it with Inf of the addend's sign.
                    inf_q    <= is_inf(acc_q) || is_inf(add_q);
                    inf_val_q <= is_inf(acc_q) ? acc_q
                               : '{sign: add_q.sign, exp: EXP_MAX, man: '0};
                end
                ST_ADD: begin
                    sum_q <= sum_d;
                end
                ST_NORM: begin
                    acc_q <= res;
                    ovf_q <= ovf_q | res_ovf;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp32_accumulator
// Directed packets (sum, cancellation, overflow, alignment drop-out,
// back-pressure, reset mid-packet, input Inf) followed by random packets
// compared against an arithmetic reference of the accumulate rules.
// -----------------------------------------------------------------------------
module tb_fp32_accumulator;

    localparam int G = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_accumulator #(.GUARD_BITS(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: one accumulate step following the arithmetic rules directly.
    function automatic logic [31:0] ref_add(input logic [31:0] acc, input logic [31:0] x,
                                            output bit hit);
        bit     sa, sb, ts;
        int     ea, eb, te, d, e;
        longint ma, mb, tm, s;
        hit = 1'b0;
        if (acc[30:23] == 8'hFF) return acc;
        if (x[30:23] == 8'hFF) begin
            hit = 1'b1;
            return {x[31], 8'hFF, 23'd0};
        end
        sa = acc[31]; ea = int'(acc[30:23]);
        ma = (ea == 0) ? 0 : (longint'({1'b1, acc[22:0]}) << G);
        sb = x[31];   eb = int'(x[30:23]);
        mb = (eb == 0) ? 0 : (longint'({1'b1, x[22:0]}) << G);
        if (eb > ea || (eb == ea && mb > ma)) begin
            ts = sa; sa = sb; sb = ts;
            te = ea; ea = eb; eb = te;
            tm = ma; ma = mb; mb = tm;
        end
        d  = ea - eb;
        mb = (d >= 24 + G) ? 0 : (mb >> d);
        s  = (sa == sb) ? ma + mb : ma - mb;
        if (s == 0) return 32'd0;
        e = ea;
        while (s >= (longint'(1) << (24 + G))) begin s = s >> 1; e++; end
        while (s <  (longint'(1) << (23 + G))) begin s = s << 1; e--; end
        if (e <= 0) return 32'd0;
        if (e >= 255) begin
            hit = 1'b1;
            return {sa, 8'hFF, 23'd0};
        end
        return {sa, e[7:0], s[22+G -: 23]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int         r;
        logic [7:0] e;
        r = int'($urandom_range(0, 19));
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r <= 3) e = 8'(250 + $urandom_range(0, 4));
        else             e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input logic [31:0] exp_d, input logic exp_o, input int hold,
                        input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, out_data, exp_d);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc_m, x;
        bit          ovf_m, hit;
        int          len;

        // Reset state.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Simple sum with latency: accept cycle, ALIGN, ADD, NORM, then OUT
        // is visible in the fourth cycle counted from the accept cycle.
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F000000, 1'b1);
        check("lat_align", 32'(out_valid), 32'd0);
        check("lat_align_inrdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("lat_add", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_norm", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_out", 32'(out_valid), 32'd1);
        recv(32'h40600000, 1'b0, 0, "simple");

        // Cancellation.
        send(32'h3F800000, 1'b0);
        send(32'hBF800000, 1'b1);
        recv(32'h00000000, 1'b0, 0, "cancel");

        // Overflow to Inf.
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);
        recv(32'h7F800000, 1'b1, 0, "overflow");

        // Alignment drop-out: 2^24 + 1.0 truncates back to 2^24.
        send(32'h4B800000, 1'b0);
        send(32'h3F800000, 1'b1);
        recv(32'h4B800000, 1'b0, 0, "dropout");

        // Back-pressure, then the next packet starts from zero.
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        recv(32'h40000000, 1'b0, 5, "bp");
        send(32'h40A00000, 1'b1);
        recv(32'h40A00000, 1'b0, 0, "bp_next");

        // Reset asserted during ADD of the second addend.
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'h40400000, 1'b1);
        recv(32'h40400000, 1'b0, 0, "midrst");

        // Infinite input replaces the sum and sticks for the packet.
        send(32'h3F800000, 1'b0);
        send(32'hFF800000, 1'b0);
        send(32'h3F800000, 1'b1);
        recv(32'hFF800000, 1'b1, 0, "in_inf");

        // Single denormal element flushes to zero.
        send(32'h00012345, 1'b1);
        recv(32'h00000000, 1'b0, 0, "denorm");

        // Random packets against the reference.
        for (int p = 0; p < 30; p++) begin
            acc_m = 32'd0;
            ovf_m = 1'b0;
            len   = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                x = rand_fp();
                send(x, k == len - 1);
                acc_m = ref_add(acc_m, x, hit);
                ovf_m = ovf_m | hit;
            end
            recv(acc_m, ovf_m, int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
